// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t : two-state sequencer encoding (IDLE, RUN)
//   RES_*   : result codes in {L,E,G} bit order
package comparator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_L    = 3'b100;
  localparam logic [2:0] RES_E    = 3'b010;
  localparam logic [2:0] RES_G    = 3'b001;

endpackage

// File: rtl/comparator_digit.sv
// Combinational DIGIT-bit magnitude compare with an optional MSB flip.
//   x, y       : digits to compare (unsigned weight)
//   invert_msb : flip the MSB of both digits (two's complement -> offset binary)
//   lt, eq, gt : exactly one is asserted
module comparator_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             invert_msb,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [DIGIT-1:0] xm;
  logic [DIGIT-1:0] ym;

  // NOTE: every always_comb output is given a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    xm            = x;
    ym            = y;
    xm[DIGIT-1]   = x[DIGIT-1] ^ invert_msb;
    ym[DIGIT-1]   = y[DIGIT-1] ^ invert_msb;
  end

  assign lt = (xm <  ym);
  assign eq = (xm == ym);
  assign gt = (xm >  ym);

endmodule

// File: rtl/comparator_nbit_serial.sv
// Registered serial magnitude comparator, MSB-first, DIGIT bits per cycle,
// with early termination at the first differing digit.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request a compare (sampled only while idle)
//   signed_mode : 0 = unsigned, 1 = two's complement (latched with start)
//   a, b        : operands (latched with start)
//   busy        : high while a compare is running
//   done        : one-cycle pulse when L/E/G become valid
//   L, E, G     : a < b, a == b, a > b; held until the next accepted start
module comparator_nbit_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("comparator_nbit_serial: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             smode;
  logic [2:0]       res;
  logic             done_q;
  logic             finish;
  logic [2:0]       res_digit;
  logic             d_lt;
  logic             d_eq;
  logic             d_gt;

  // Offset-binary only applies to the sign digit, i.e. digit 0.
  comparator_digit #(.DIGIT(DIGIT)) u_digit (
    .x          (sh_a[WIDTH-1 -: DIGIT]),
    .y          (sh_b[WIDTH-1 -: DIGIT]),
    .invert_msb (smode && (cnt == '0)),
    .lt         (d_lt),
    .eq         (d_eq),
    .gt         (d_gt)
  );

  assign res_digit = d_lt ? RES_L : (d_gt ? RES_G : RES_E);

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (!d_eq || cnt == LAST) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      smode  <= 1'b0;
      res    <= RES_NONE;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            smode <= signed_mode;
            cnt   <= '0;
            res   <= RES_NONE;
          end
        end
        RUN: begin
          if (finish) begin
            res <= res_digit;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign {L, E, G} = res;

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// Self-checking bench: a DIGIT=1 and a DIGIT=2 instance share stimulus and
// are checked cycle-by-cycle against an arithmetic reference model.
module tb_comparator_nbit_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy1, done1, l1, e1, g1;
  logic         busy2, done2, l2, e2, g2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  comparator_nbit_serial #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .L(l1), .E(e1), .G(g1)
  );

  comparator_nbit_serial #(.WIDTH(W), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy2), .done(done2), .L(l2), .E(e2), .G(g2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the first differing digit, or the last index when equal:
  // this is also the number of cycles spent before the decision cycle.
  function automatic int diff_index(input logic [W-1:0] x, input logic [W-1:0] y, input int d);
    int xi = int'(x);
    int yi = int'(y);
    for (int i = 0; i < W / d; i++) begin
      if (((xi >> (W - (i + 1) * d)) % (1 << d)) != ((yi >> (W - (i + 1) * d)) % (1 << d)))
        return i;
    end
    return W / d - 1;
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
    int xv;
    int yv;
    if (sm) begin
      xv = int'($signed(x));
      yv = int'($signed(y));
    end else begin
      xv = int'(x);
      yv = int'(y);
    end
    if (xv < yv)  return 3'b100;
    if (xv == yv) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, " busy1"}, busy1, 0);
    check({tag, " done1"}, done1, 0);
    check({tag, " leg1"}, {l1, e1, g1}, 0);
    check({tag, " busy2"}, busy2, 0);
    check({tag, " done2"}, done2, 0);
    check({tag, " leg2"}, {l2, e2, g2}, 0);
  endtask

  // Issue one compare and check both instances every cycle until both have
  // finished. restart_at > 0 pulses start with other operands at that cycle.
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic sm, input int restart_at);
    int         k1;
    int         k2;
    logic [2:0] r;
    k1 = diff_index(xa, xb, 1);
    k2 = diff_index(xa, xb, 2);
    r  = ref_res(xa, xb, sm);
    @(negedge clk);
    a = xa; b = xb; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
    for (int n = 1; n <= W + 2; n++) begin
      if (n > 1) @(negedge clk);
      check($sformatf("%s n=%0d busy1", name, n), busy1, (n <= k1 + 1));
      check($sformatf("%s n=%0d done1", name, n), done1, (n == k1 + 2));
      check($sformatf("%s n=%0d leg1", name, n), {l1, e1, g1}, (n >= k1 + 2) ? r : 3'b000);
      check($sformatf("%s n=%0d busy2", name, n), busy2, (n <= k2 + 1));
      check($sformatf("%s n=%0d done2", name, n), done2, (n == k2 + 2));
      check($sformatf("%s n=%0d leg2", name, n), {l2, e2, g2}, (n >= k2 + 2) ? r : 3'b000);
      if (restart_at > 0) begin
        start = (n == restart_at);
        if (n == restart_at) begin
          a = 8'h00; b = 8'hFF; signed_mode = 1'b0;
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset held with start high: nothing may be accepted.
    rst = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 8'h12; b = 8'h34;
    @(negedge clk);
    check_idle_zero("reset c1");
    @(negedge clk);
    check_idle_zero("reset c2");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle_zero("post reset");

    // Directed cases.
    run_op("eq_a5", 8'hA5, 8'hA5, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("eq_a5 hold1", {l1, e1, g1}, 3'b010);
    check("eq_a5 hold2", {l2, e2, g2}, 3'b010);
    run_op("u80_7f", 8'h80, 8'h7F, 1'b0, 0);
    run_op("s80_7f", 8'h80, 8'h7F, 1'b1, 0);
    run_op("u12_13", 8'h12, 8'h13, 1'b0, 0);
    run_op("sfe_ff", 8'hFE, 8'hFF, 1'b1, 0);
    run_op("s7f_80", 8'h7F, 8'h80, 1'b1, 0);
    run_op("restart", 8'h3C, 8'h3C, 1'b0, 2);

    // Reset on the third RUN cycle abandons the compare.
    @(negedge clk);
    a = 8'h00; b = 8'h01; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort n1 busy1", busy1, 1);
    check("abort n1 busy2", busy2, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort after rst");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("abort quiet%0d done1", i), done1, 0);
      check($sformatf("abort quiet%0d done2", i), done2, 0);
    end
    run_op("fresh", 8'h00, 8'h01, 1'b0, 0);

    // Randomised compares, biased toward long common prefixes.
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_op($sformatf("rnd%0d", t), ra, rb, 1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/comparator_nbit_serial.md
# comparator_nbit_serial

Parametrised, registered magnitude comparator for two WIDTH-bit operands. It processes operands MSB-first, DIGIT bits per cycle, and terminates early at the first differing digit. It supports unsigned and two's-complement modes, selected per operation. It generalises the combinational 1-bit L/E/G comparator into a start/busy/done sequential block for datapaths that trade latency for area.

## Interface

Parameters:
- WIDTH, default 8: operand width in bits; must be ≥ 1.
- DIGIT, default 1: bits compared per cycle; must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0. Elaboration fails otherwise.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a comparison. Sampled only when idle.
- signed_mode, input, 1: 0 = unsigned, 1 = two's complement. Latched with start.
- a, input, WIDTH: operand A. Latched with start.
- b, input, WIDTH: operand B. Latched with start.
- busy, output, 1: high while a comparison is in progress.
- done, output, 1: one-cycle pulse when the result becomes valid.
- L, output, 1: A < B.
- E, output, 1: A == B.
- G, output, 1: A > B.

## Operation

- NDIG = WIDTH/DIGIT digit positions. Digit index 0 is the most significant.
- The FSM has two states, IDLE and RUN.
- IDLE:
  - start = 1 at an edge latches a, b and signed_mode into shift registers.
  - Loads the digit counter with 0.
  - Clears L/E/G to 000 and moves to RUN.
  - start = 0 leaves the block in IDLE with L/E/G held.
- RUN, on each edge:
  - Compares the top DIGIT bits of the A and B shift registers.
  - In signed mode, only digit 0 has its MSB inverted in both operands (offset-binary), so negative < positive.
  - Digits unequal: set exactly one of L or G from the digit compare, pulse done, go to IDLE.
  - Digits equal and counter = NDIG−1: set E, pulse done, go to IDLE.
  - Otherwise: shift both registers left by DIGIT, increment the counter, stay in RUN.
- busy = 1 exactly in RUN.
- start while in RUN is ignored. No queueing.
- Operand or mode changes after acceptance have no effect on the current operation.
- After done, exactly one of L/E/G is 1. They hold until the next accepted start or rst.
- A start asserted in the same cycle that done is produced is not accepted, because the FSM is still in RUN. It is accepted one cycle later if still high.
- Reset:
  - rst = 1 at any edge forces IDLE, busy = 0, done = 0, L/E/G = 000.
  - Reset clears the counter and shift registers. rst wins over start.
  - Reset mid-RUN abandons the operation with no done pulse.

## Timing

- Reset values: busy 0, done 0, L 0, E 0, G 0.
- Start accepted at edge T: busy = 1 from T until the decision edge.
- If the first differing digit has index k, the decision edge is T + k + 1. done = 1 for exactly the cycle after that edge, and busy = 0 in that cycle.
- Latency ranges from a minimum of 1 cycle (digit 0 differs) to a maximum of NDIG cycles (equal operands, or a difference in the last digit).
- L/E/G and done change only on clock edges. All outputs are registered, with no combinational path from inputs.
- Back-to-back throughput: one operation per k + 2 cycles, with start held high.

## Structure

- Shared package comparator_pkg:
  - state enum {IDLE, RUN}.
  - Result encoding constants: RES_NONE = 3'b000, RES_L = 3'b100, RES_E = 3'b010, RES_G = 3'b001, in the order {L,E,G}.
- Sub-module comparator_digit:
  - Combinational, parameter DIGIT.
  - Inputs: x, y, invert_msb.
  - Outputs: lt, eq, gt, with exactly one asserted.
  - Instantiated once on the shift-register tops.
- Top level holds the FSM, the counter (width $clog2(NDIG) with a minimum of 1), the shift registers and the output registers.

## Test plan

1. Assert rst for 2 cycles with start = 1 → busy, done and L/E/G stay 0. No operation is accepted while rst = 1.
2. WIDTH = 8, DIGIT = 1, unsigned, a = 0xA5, b = 0xA5 → busy for 8 cycles, then done pulse, then {L,E,G} = 010, held until the next start.
3. WIDTH = 8, DIGIT = 1, unsigned, a = 0x80, b = 0x7F → decision after 1 cycle, {L,E,G} = 001. Same operands with signed_mode = 1 → {L,E,G} = 100 after 1 cycle.
4. WIDTH = 8, DIGIT = 2, unsigned, a = 0x12, b = 0x13 → digits differ at index 3, done 4 cycles after acceptance, {L,E,G} = 100. Signed a = 0xFE (−2), b = 0xFF (−1) → {L,E,G} = 100 after 4 cycles.
5. Pulse start again 2 cycles into a running compare with different operands → ignored. The result matches the first operands, and only one done pulse occurs.
6. Start a = 0x00, b = 0x01 (DIGIT = 1), then assert rst on the 3rd RUN cycle → next cycle busy = 0, L/E/G = 000, and no done pulse ever appears. A fresh start afterwards completes normally.
